accel_movement_source: RTL and testbench

//   SPI master that reads X/Y tilt from the on-board ADXL362 accelerometer.

---
 rtl/accel_movement_source_pkg.sv | 38 +++
 rtl/accel_movement_source_if.sv | 10 +
 rtl/accel_movement_source_byte_engine.sv | 72 +++++++
 rtl/accel_movement_source.sv | 190 +++++++++++++++++++
 tb/tb_accel_movement_source.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/accel_movement_source_pkg.sv
// Shared definitions for the accelerometer movement source: ADXL362 command bytes,
// movement word widths, FSM state type and the axis shift/saturate helpers.
package movement_defs;

    localparam logic [7:0] ADXL_CMD_WR   = 8'h0A;
    localparam logic [7:0] ADXL_CMD_RD   = 8'h0B;
    localparam logic [7:0] REG_POWER_CTL = 8'h2D;
    localparam logic [7:0] PWR_MEASURE   = 8'h02;
    localparam logic [7:0] REG_XDATA     = 8'h08;

    localparam int MOVE_W = 10;
    localparam int AXIS_W = 5;

    typedef enum logic [2:0] {
        ST_WAIT,
        ST_CFG,
        ST_IDLE,
        ST_READ,
        ST_PACK
    } state_t;

    function automatic logic [AXIS_W-1:0] sat_axis(input logic [7:0] v, input int shift);
        logic signed [7:0] s;
        s = $signed(v) >>> shift;
        if (s > 8'sd15)
            return 5'b01111;
        else if (s < -8'sd16)
            return 5'b10000;
        return s[AXIS_W-1:0];
    endfunction

    function automatic logic in_deadzone(input logic [AXIS_W-1:0] a, input int dz);
        int sv;
        sv = int'($signed(a));
        return (sv <= dz) && (sv >= -dz);
    endfunction

endpackage

// File: rtl/accel_movement_source_if.sv
// SPI bus between the movement source (master) and the ADXL362 (slave).
interface accel_spi_if;
    logic sclk;
    logic mosi;
    logic miso;
    logic cs_n;

    modport master (output sclk, output mosi, output cs_n, input miso);
    modport slave  (input sclk, input mosi, input cs_n, output miso);
endinterface

// File: rtl/accel_movement_source_byte_engine.sv
// Mode-0 SPI byte shifter. A byte offered with start while the previous byte's
// last falling edge is being issued is chained with no gap.
module spi_byte_engine #(
    parameter int CLK_DIV = 50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data,
    input  logic       miso,
    output logic       sclk,
    output logic       mosi,
    output logic       done,
    output logic [7:0] rx
);
    localparam int DW = $clog2(CLK_DIV + 1);

    logic          busy;
    logic [DW-1:0] cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;

    always_ff @(posedge clk) begin
        if (rst) begin
            busy    <= 1'b0;
            cnt     <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            sclk    <= 1'b0;
            mosi    <= 1'b0;
            done    <= 1'b0;
            rx      <= '0;
        end else begin
            done <= 1'b0;
            if (!busy) begin
                if (start) begin
                    // First half-period is one short: the caller spent a cycle raising start.
                    busy    <= 1'b1;
                    shreg   <= data;
                    mosi    <= data[7];
                    bit_cnt <= '0;
                    cnt     <= DW'(CLK_DIV - 2);
                end
            end else if (cnt != '0) begin
                cnt <= cnt - 1'b1;
            end else begin
                cnt <= DW'(CLK_DIV - 1);
                if (!sclk) begin
                    sclk <= 1'b1;
                    rx   <= {rx[6:0], miso};
                end else begin
                    sclk <= 1'b0;
                    if (bit_cnt == 3'd7) begin
                        done <= 1'b1;
                        if (start) begin
                            shreg   <= data;
                            mosi    <= data[7];
                            bit_cnt <= '0;
                        end else begin
                            busy <= 1'b0;
                            mosi <= 1'b0;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                        shreg   <= {shreg[6:0], 1'b0};
                        mosi    <= shreg[6];
                    end
                end
            end
        end
    end
endmodule

// File: rtl/accel_movement_source.sv
// ADXL362 reader producing the {x5, y5} maze movement word.
// Optional MOVE_DEADZONE_EN zeroes axes whose magnitude is within DEADZONE.
//
// state | meaning
// WAIT  | sensor power-up delay after reset
// CFG   | write POWER_CTL = measure
// IDLE  | cs_n high, waiting for sample tick and CS gap
// READ  | burst read of XDATA/YDATA
// PACK  | convert axes, publish movement word
module accel_movement_source
    import movement_defs::*;
#(
    parameter int CLK_DIV        = 50,
    parameter int STARTUP_CYCLES = 500000,
    parameter int SAMPLE_PERIOD  = 1666667,
    parameter int CS_GAP         = 100,
    parameter int SHIFT          = 3,
    parameter int DEADZONE       = 1
) (
    input  logic              in_clk,
    input  logic              reset,
    accel_spi_if.master       spi,
    output logic [MOVE_W-1:0] movement_data,
    output logic              movement_valid,
    output logic              init_done
);
    localparam int DW = $clog2(CLK_DIV + 1);
    localparam int WW = $clog2(STARTUP_CYCLES + 1);
    localparam int SW = $clog2(SAMPLE_PERIOD + 1);
    localparam int GW = $clog2(CS_GAP + 1);
`ifdef MOVE_DEADZONE_EN
    localparam bit DZ_EN = 1'b1;
`else
    localparam bit DZ_EN = 1'b0;
`endif

    state_t        state;
    logic          cs_n;
    logic [WW-1:0] wait_cnt;
    logic [SW-1:0] sample_cnt;
    logic [GW-1:0] gap_cnt;
    logic [DW-1:0] tail_cnt;
    logic [2:0]    byte_cnt;
    logic          launched;
    logic          tail;
    logic          pending;
    logic [7:0]    x_raw;
    logic [7:0]    y_raw;

    logic          eng_start;
    logic [7:0]    eng_data;
    logic          eng_done;
    logic [7:0]    eng_rx;
    logic          eng_sclk;
    logic          eng_mosi;
    logic [2:0]    frame_len;
    logic [2:0]    next_idx;
    logic          tick;

    function automatic logic [AXIS_W-1:0] conv_axis(input logic [7:0] v);
        logic [AXIS_W-1:0] s;
        s = sat_axis(v, SHIFT);
        return (DZ_EN && in_deadzone(s, DEADZONE)) ? '0 : s;
    endfunction

    assign tick      = init_done && (sample_cnt == '0);
    assign frame_len = (state == ST_CFG) ? 3'd3 : 3'd4;
    // Once the first byte is launched, the engine is always one byte ahead of the done count.
    assign next_idx  = launched ? byte_cnt + 3'd1 : 3'd0;

    always_comb begin
        eng_data  = 8'h00;
        eng_start = (state == ST_CFG || state == ST_READ) && !cs_n && !tail && (next_idx < frame_len);
        if (state == ST_CFG) begin
            case (next_idx)
                3'd0:    eng_data = ADXL_CMD_WR;
                3'd1:    eng_data = REG_POWER_CTL;
                3'd2:    eng_data = PWR_MEASURE;
                default: eng_data = 8'h00;
            endcase
        end else begin
            case (next_idx)
                3'd0:    eng_data = ADXL_CMD_RD;
                3'd1:    eng_data = REG_XDATA;
                default: eng_data = 8'h00;
            endcase
        end
    end

    spi_byte_engine #(.CLK_DIV(CLK_DIV)) u_engine (
        .clk   (in_clk),
        .rst   (reset),
        .start (eng_start),
        .data  (eng_data),
        .miso  (spi.miso),
        .sclk  (eng_sclk),
        .mosi  (eng_mosi),
        .done  (eng_done),
        .rx    (eng_rx)
    );

    assign spi.sclk = eng_sclk;
    assign spi.mosi = eng_mosi;
    assign spi.cs_n = cs_n;

    always_ff @(posedge in_clk) begin
        if (reset) begin
            state          <= ST_WAIT;
            cs_n           <= 1'b1;
            init_done      <= 1'b0;
            movement_data  <= '0;
            movement_valid <= 1'b0;
            wait_cnt       <= WW'(STARTUP_CYCLES - 1);
            sample_cnt     <= '0;
            gap_cnt        <= '0;
            tail_cnt       <= '0;
            byte_cnt       <= '0;
            launched       <= 1'b0;
            tail           <= 1'b0;
            pending        <= 1'b0;
            x_raw          <= '0;
            y_raw          <= '0;
        end else begin
            movement_valid <= 1'b0;
            if (gap_cnt != '0)
                gap_cnt <= gap_cnt - 1'b1;
            if (init_done)
                sample_cnt <= (sample_cnt == '0) ? SW'(SAMPLE_PERIOD - 1) : sample_cnt - 1'b1;

            case (state)
                ST_WAIT: begin
                    if (wait_cnt == '0) begin
                        state <= ST_CFG;
                        cs_n  <= 1'b0;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                ST_CFG, ST_READ: begin
                    if (eng_start && !launched)
                        launched <= 1'b1;
                    if (eng_done) begin
                        byte_cnt <= byte_cnt + 3'd1;
                        if (state == ST_READ && byte_cnt == 3'd2)
                            x_raw <= eng_rx;
                        if (state == ST_READ && byte_cnt == 3'd3)
                            y_raw <= eng_rx;
                        if (byte_cnt == frame_len - 3'd1) begin
                            tail     <= 1'b1;
                            tail_cnt <= DW'(CLK_DIV - 2);
                        end
                    end
                    if (tail) begin
                        if (tail_cnt != '0) begin
                            tail_cnt <= tail_cnt - 1'b1;
                        end else begin
                            cs_n     <= 1'b1;
                            tail     <= 1'b0;
                            launched <= 1'b0;
                            byte_cnt <= '0;
                            gap_cnt  <= GW'(CS_GAP - 1);
                            if (state == ST_CFG) begin
                                init_done  <= 1'b1;
                                sample_cnt <= SW'(SAMPLE_PERIOD - 1);
                                state      <= ST_IDLE;
                            end else begin
                                state <= ST_PACK;
                            end
                        end
                    end
                end
                ST_IDLE: begin
                    if ((tick || pending) && gap_cnt == '0) begin
                        state   <= ST_READ;
                        cs_n    <= 1'b0;
                        pending <= 1'b0;
                    end else if (tick) begin
                        pending <= 1'b1;
                    end
                end
                ST_PACK: begin
                    movement_data  <= {conv_axis(x_raw), conv_axis(y_raw)};
                    movement_valid <= 1'b1;
                    state          <= ST_IDLE;
                end
                default: state <= ST_WAIT;
            endcase
        end
    end
endmodule

// File: tb/tb_accel_movement_source.sv
// Directed bench for accel_movement_source with an ADXL362 SPI slave model.
module tb_accel_movement_source;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [9:0] movement_data;
    logic       movement_valid;
    logic       init_done;

    accel_spi_if spi();

    accel_movement_source #(
        .CLK_DIV(2), .STARTUP_CYCLES(20), .SAMPLE_PERIOD(2000)
    ) dut (
        .in_clk         (clk),
        .reset          (reset),
        .spi            (spi),
        .movement_data  (movement_data),
        .movement_valid (movement_valid),
        .init_done      (init_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // Sensor model: collects MOSI on rising edges, presents MISO after falling edges.
    logic [7:0]  mdl_x = 8'h00;
    logic [7:0]  mdl_y = 8'h00;
    logic        miso_r = 1'b0;
    logic        prev_cs = 1'b1;
    logic        prev_sclk = 1'b0;
    logic [31:0] mosi_sh = '0;
    logic [31:0] last_mosi = '0;
    int          rises = 0;
    int          last_rises = 0;
    int          frames = 0;

    assign spi.miso = miso_r;

    function automatic logic miso_bit(input int n);
        logic [7:0] b;
        b = (n / 8 == 2) ? mdl_x : (n / 8 == 3) ? mdl_y : 8'h00;
        return b[7 - (n % 8)];
    endfunction

    always @(spi.cs_n or spi.sclk) begin
        if (spi.cs_n !== prev_cs) begin
            if (spi.cs_n === 1'b0) begin
                rises   = 0;
                mosi_sh = '0;
                miso_r  = miso_bit(0);
            end else if (spi.cs_n === 1'b1 && prev_cs === 1'b0) begin
                frames++;
                last_mosi  = mosi_sh;
                last_rises = rises;
            end
            prev_cs = spi.cs_n;
        end
        if (spi.sclk !== prev_sclk) begin
            if (spi.cs_n === 1'b0) begin
                if (spi.sclk === 1'b1) begin
                    mosi_sh = {mosi_sh[30:0], spi.mosi};
                    rises++;
                end else begin
                    miso_r = miso_bit(rises);
                end
            end
            prev_sclk = spi.sclk;
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(input int budget, output bit ok, output int at);
        ok = 1'b0;
        at = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (movement_valid === 1'b1) begin
                ok = 1'b1;
                at = cyc;
                break;
            end
        end
    endtask

    task automatic wait_init(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (init_done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_read_bit(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (spi.cs_n === 1'b0 && rises >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    bit          ok;
    int          t1, t2, t3, f0;
    logic [31:0] dz_exp;

    initial begin
`ifdef MOVE_DEADZONE_EN
        dz_exp = 32'h000;
`else
        dz_exp = 32'h020;
`endif
        repeat (3) @(negedge clk);
        chk("rst_cs_n",  32'(spi.cs_n), 32'd1);
        chk("rst_sclk",  32'(spi.sclk), 32'd0);
        chk("rst_mosi",  32'(spi.mosi), 32'd0);
        chk("rst_data",  32'(movement_data), 32'h000);
        chk("rst_valid", 32'(movement_valid), 32'd0);
        chk("rst_init",  32'(init_done), 32'd0);

        f0 = frames;
        reset = 1'b0;
        wait_init(400, ok);
        chk("cfg_timeout", 32'(ok), 32'd1);
        chk("cfg_frames",  32'(frames - f0), 32'd1);
        chk("cfg_mosi",    last_mosi, 32'h000A2D02);
        chk("cfg_bits",    32'(last_rises), 32'd24);
        chk("cfg_cs_high", 32'(spi.cs_n), 32'd1);

        mdl_x = 8'h18; mdl_y = 8'hF0;
        wait_valid(3000, ok, t1);
        chk("rd1_timeout", 32'(ok), 32'd1);
        chk("rd1_data",    32'(movement_data), 32'h07E);
        chk("rd1_mosi",    last_mosi, 32'h0B080000);
        chk("rd1_bits",    32'(last_rises), 32'd32);
        @(negedge clk);
        chk("valid_width", 32'(movement_valid), 32'd0);
        mdl_x = 8'h7F; mdl_y = 8'h80;
        repeat (10) @(negedge clk);
        chk("data_hold",   32'(movement_data), 32'h07E);

        wait_valid(3000, ok, t2);
        chk("rd2_timeout", 32'(ok), 32'd1);
        chk("sat_data",    32'(movement_data), 32'h1F0);
        chk("cadence1",    32'(t2 - t1), 32'd2000);
        chk("rd2_bits",    32'(last_rises), 32'd32);

        mdl_x = 8'h08; mdl_y = 8'h00;
        wait_valid(3000, ok, t3);
        chk("rd3_timeout", 32'(ok), 32'd1);
        chk("dz_data",     32'(movement_data), dz_exp);
        chk("cadence2",    32'(t3 - t2), 32'd2000);

        mdl_x = 8'h18; mdl_y = 8'hF0;
        wait_read_bit(20, 3000, ok);
        chk("mid_read_timeout", 32'(ok), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_cs_n",  32'(spi.cs_n), 32'd1);
        chk("mid_sclk",  32'(spi.sclk), 32'd0);
        chk("mid_data",  32'(movement_data), 32'h000);
        chk("mid_init",  32'(init_done), 32'd0);
        chk("mid_valid", 32'(movement_valid), 32'd0);
        f0 = frames;
        reset = 1'b0;
        wait_init(400, ok);
        chk("recfg_timeout", 32'(ok), 32'd1);
        chk("recfg_frames",  32'(frames - f0), 32'd1);
        chk("recfg_mosi",    last_mosi, 32'h000A2D02);
        chk("recfg_bits",    32'(last_rises), 32'd24);

        wait_valid(3000, ok, t1);
        chk("rd4_timeout", 32'(ok), 32'd1);
        chk("rd4_data",    32'(movement_data), 32'h07E);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
